simple_out_monitor: RTL
=======================

// Module: simple_out_monitor
// PURPOSE
// - Downstream stage of the simple core. Consumes the core's `out` net.
// - Synchronises `out` into iccad_clk and detects every level change.
// - Measures how long `out` held each level (run length, in clock cycles).
// - Queues one event record per transition and emits it on a valid/ready stream to the debug/trace collector.
// PARAMETERS
// - CNT_W  default 8  run-length counter width; the counter saturates at 2**CNT_W-1.
// - DEPTH  default 4  event FIFO entries; must be a power of 2 and >= 2.
// PORTS
// - iccad_clk    in   1        single clock for all state
// - iccad_rst_n  in   1        asynchronous, active-low reset
// - mon_in       in   1        the core's `out` net; asynchronous to this block, so it is synchronised here
// - en           in   1        1 = monitor runs; 0 = hold counters and push nothing
// - evt_valid    out  1        event record available
// - evt_ready    in   1        consumer accepts the record this cycle
// - evt_level    out  1        level that `out` held before the transition
// - evt_len      out  CNT_W    cycles that level was held (saturated)
// - evt_count    out  $clog2(DEPTH)+1  current FIFO occupancy
// - ovf          out  1        sticky flag: an event was dropped
// - clr_ovf      in   1        synchronous clear of ovf
// BEHAVIOUR
// - Reset values (asynchronous, iccad_rst_n=0):
//   - sync_q1 = sync_q2 = prev_lvl = 0
//   - run_cnt = 0, FIFO empty, evt_valid = 0, evt_count = 0, ovf = 0
//   - evt_level and evt_len read 0 while the FIFO is empty.
// - Synchroniser: two flops, mon_in -> sync_q1 -> sync_q2.
// - Edge detect: edge = en & (sync_q2 != prev_lvl). prev_lvl <= sync_q2 every cycle, even when en=0.
// - Run counter:
//   - edge cycle: push {prev_lvl, sat(run_cnt+1)}, then run_cnt <= 0.
//   - else if en: run_cnt <= sat(run_cnt+1).
//   - else: hold.
//   - sat(x): if run_cnt is already all-ones, the result stays all-ones; no wrap.
// - Latency: if mon_in changes before iccad_clk edge E1, evt_valid goes high after edge E3 (3 cycles).
// - FIFO: show-ahead. evt_valid = !empty. evt_level and evt_len are driven from the head entry (combinational read).
//   - pop  = evt_valid & evt_ready
//   - push = edge & (!full | pop)
// - Full and popping in the same cycle: the push is accepted; occupancy is unchanged.
// - Empty with a push: evt_valid rises on the next cycle. There is no same-cycle bypass.
// - Dropped event: edge & full & !pop drops the record and sets ovf <= 1. run_cnt still clears to 0.
// - ovf clear: clr_ovf clears ovf. If a drop happens in the same cycle, set wins (ovf stays 1).
// - Pointers: width log2(DEPTH); they wrap modulo DEPTH. Occupancy is tracked by the counter.
// - Stream rule: once evt_valid is high, the head record stays stable until it is popped.
// - Mid-operation reset: everything returns immediately to the reset values. Queued events are lost; no partial record survives.
// - en=0 effects: no pushes and run_cnt frozen. Pops still proceed.
//   - Level changes while en=0 are absorbed silently: prev_lvl tracks sync_q2.
// - Glitches: a pulse on mon_in shorter than one cycle may be missed; this is accepted.
// STRUCTURE
// - Shared package simple_mon_pkg:
//   - typedef mon_evt_t = struct {logic level; logic [CNT_W-1:0] len}
//   - localparam MON_CNT_W_DEF = 8
// - Sub-module simple_evt_fifo: parameterised on the record width and DEPTH. Provides push/pop, full/empty, count.
// - Top level holds the synchroniser, edge detect, run counter and ovf flag.
// TESTING
// - T1 Reset: assert iccad_rst_n=0 mid-stream with 3 events queued -> evt_valid=0, evt_count=0, ovf=0 immediately.
// - T2 Basic: en=1, hold mon_in=0 for 10 cycles, then set it to 1 -> 3 cycles later evt_valid=1, evt_level=0, evt_len=10 (+/-1 for sync phase; the bench checks the exact value).
// - T3 Saturation: CNT_W=8, hold mon_in=1 for 300 cycles, then toggle -> evt_len=255, evt_level=1.
// - T4 Overflow: evt_ready=0, DEPTH=4, generate 6 edges -> evt_count=4, ovf=1; the 4 records kept are the oldest; clr_ovf -> ovf=0.
// - T5 Full with push and pop in the same cycle: FIFO full, evt_ready=1 on the edge cycle -> count stays 4, ovf stays 0, order preserved.
// - T6 Enable: en=0 while mon_in toggles 5 times -> no events; re-enable with one toggle -> exactly one event, run length counted from re-enable.

Source files
------------

// File: rtl/simple_mon_pkg.sv
// Shared types and defaults for the simple core output monitor.
package simple_mon_pkg;

   localparam int MON_CNT_W_DEF = 8;
   localparam int MON_DEPTH_DEF = 4;

   typedef struct packed {
      logic                     level;
      logic [MON_CNT_W_DEF-1:0] len;
   } mon_evt_t;

endpackage

// File: rtl/simple_evt_fifo.sv
// Show-ahead event FIFO: head entry is visible combinationally, reads zero when empty.
module simple_evt_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wr_data,
   output logic [W-1:0]               rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // When full, a simultaneous pop frees the slot the write lands in.
   assign do_push = push & (~full | do_pop);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/simple_out_monitor.sv
// Watches the core's out net: synchronises it, measures run lengths and queues one record per transition.
module simple_out_monitor
   import simple_mon_pkg::*;
#(
   parameter int CNT_W = MON_CNT_W_DEF,
   parameter int DEPTH = MON_DEPTH_DEF
) (
   input  logic                       iccad_clk,
   input  logic                       iccad_rst_n,
   input  logic                       mon_in,
   input  logic                       en,
   output logic                       evt_valid,
   input  logic                       evt_ready,
   output logic                       evt_level,
   output logic [CNT_W-1:0]           evt_len,
   output logic [$clog2(DEPTH):0]     evt_count,
   output logic                       ovf,
   input  logic                       clr_ovf
);

   typedef struct packed {
      logic             level;
      logic [CNT_W-1:0] len;
   } evt_rec_t;

   logic             sync_q1;
   logic             sync_q2;
   logic             prev_lvl;
   logic [CNT_W-1:0] run_cnt;
   logic [CNT_W-1:0] run_next;
   logic             evt_edge;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   evt_rec_t         push_rec;
   evt_rec_t         head_rec;

   assign evt_edge = en & (sync_q2 != prev_lvl);
   assign run_next = (&run_cnt) ? run_cnt : run_cnt + 1'b1;
   assign pop      = evt_valid & evt_ready;
   assign push     = evt_edge & (~fifo_full | pop);
   assign push_rec = '{level: prev_lvl, len: run_next};

   assign evt_valid = ~fifo_empty;
   assign evt_level = head_rec.level;
   assign evt_len   = head_rec.len;

   // prev_lvl follows the synchronised level even while disabled, so changes seen with en=0 never surface later.
   always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
      if (!iccad_rst_n) begin
         sync_q1  <= 1'b0;
         sync_q2  <= 1'b0;
         prev_lvl <= 1'b0;
      end else begin
         sync_q1  <= mon_in;
         sync_q2  <= sync_q1;
         prev_lvl <= sync_q2;
      end
   end

   always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
      if (!iccad_rst_n) begin
         run_cnt <= '0;
      end else if (evt_edge) begin
         run_cnt <= '0;
      end else if (en) begin
         run_cnt <= run_next;
      end
   end

   // A drop takes priority over a clear landing in the same cycle.
   always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
      if (!iccad_rst_n) begin
         ovf <= 1'b0;
      end else if (evt_edge & fifo_full & ~pop) begin
         ovf <= 1'b1;
      end else if (clr_ovf) begin
         ovf <= 1'b0;
      end
   end

   simple_evt_fifo #(
      .W     ($bits(evt_rec_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (iccad_clk),
      .rst_n   (iccad_rst_n),
      .push    (push),
      .pop     (pop),
      .wr_data (push_rec),
      .rd_data (head_rec),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (evt_count)
   );

endmodule
